// File: rtl/nfc_multi_chan_sched.sv
// nfc_multi_chan_sched: multi-channel NAND command scheduler.
// Queues host commands and dispatches each to the channel selected by the low
// row-address bits. It also gathers per-channel completion results into a
// show-ahead status FIFO.
//
// Handshakes: a transfer happens on any rising CLK edge where valid and ready
// are both high.
// - cmd_valid/cmd_ready: cmd_ready depends only on registered state.
// - sts_valid/sts_ready: sts_* are stable while sts_valid is high and no pop occurs.
// - ch_strt/ch_done: single-cycle pulses. ch_cmd/ch_rwa are valid with ch_strt.
module nfc_multi_chan_sched #(
    parameter int NUM_CH         = 4,
    parameter int ROW_ADDR_WIDTH = 24,
    parameter int QDEPTH         = 8,
    parameter int SDEPTH         = 8,
    parameter int TAG_WIDTH      = 4,
    localparam int CHW           = $clog2(NUM_CH),
    localparam int QCW           = $clog2(QDEPTH) + 1
) (
    input  logic                             CLK,
    input  logic                             RES,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_op,
    input  logic [ROW_ADDR_WIDTH-1:0]        cmd_row,
    input  logic [TAG_WIDTH-1:0]             cmd_tag,
    output logic [NUM_CH-1:0]                ch_strt,
    output logic [3*NUM_CH-1:0]              ch_cmd,
    output logic [NUM_CH*ROW_ADDR_WIDTH-1:0] ch_rwa,
    input  logic [NUM_CH-1:0]                ch_done,
    input  logic [NUM_CH-1:0]                ch_perr,
    input  logic [NUM_CH-1:0]                ch_eerr,
    input  logic [NUM_CH-1:0]                ch_rerr,
    output logic                             sts_valid,
    input  logic                             sts_ready,
    output logic [TAG_WIDTH-1:0]             sts_tag,
    output logic [CHW-1:0]                   sts_ch,
    output logic [2:0]                       sts_err,
    output logic                             sts_illegal,
    output logic [NUM_CH-1:0]                ch_busy,
    output logic [QCW-1:0]                   q_count
);
    localparam int QAW = $clog2(QDEPTH);
    localparam int SAW = $clog2(SDEPTH);
    localparam int RW  = ROW_ADDR_WIDTH;
    localparam int TW  = TAG_WIDTH;

    // Command queue storage and pointers
    logic [2:0]     q_op_mem  [QDEPTH];
    logic [RW-1:0]  q_row_mem [QDEPTH];
    logic [TW-1:0]  q_tag_mem [QDEPTH];
    logic [QAW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [QAW:0]   q_cnt_q, q_cnt_d;

    // Status FIFO storage and pointers
    logic [TW-1:0]  s_tag_mem [SDEPTH];
    logic [CHW-1:0] s_ch_mem  [SDEPTH];
    logic [2:0]     s_err_mem [SDEPTH];
    logic           s_ill_mem [SDEPTH];
    logic [SAW-1:0] s_wr_q, s_wr_d, s_rd_q, s_rd_d;
    logic [SAW:0]   s_cnt_q, s_cnt_d;

    // Per-channel ownership, pending completion and the command it holds
    logic [NUM_CH-1:0] busy_q, busy_d, pend_q, pend_d;
    logic [2:0]        err_q [NUM_CH];
    logic [2:0]        err_d [NUM_CH];
    logic [2:0]        cmd_q [NUM_CH];
    logic [2:0]        cmd_d [NUM_CH];
    logic [RW-1:0]     rwa_q [NUM_CH];
    logic [RW-1:0]     rwa_d [NUM_CH];
    logic [TW-1:0]     tag_q [NUM_CH];
    logic [TW-1:0]     tag_d [NUM_CH];
    logic [CHW-1:0]    rr_q, rr_d;   // first channel examined by the arbiter

    logic [2:0]     head_op;
    logic [RW-1:0]  head_row;
    logic [TW-1:0]  head_tag;
    logic [CHW-1:0] head_ch;
    logic           head_legal, q_empty, q_push, q_pop, disp;
    logic           s_full, s_push, s_pop, srv_found, srv_wr, ill_wr;
    logic [CHW-1:0] srv_ch, idx;
    logic [TW-1:0]  w_tag;
    logic [CHW-1:0] w_ch;
    logic [2:0]     w_err;
    logic           w_ill;

    assign head_op    = q_op_mem[q_rd_q];
    assign head_row   = q_row_mem[q_rd_q];
    assign head_tag   = q_tag_mem[q_rd_q];
    assign head_ch    = head_row[CHW-1:0];
    assign head_legal = (head_op >= 3'd1) && (head_op <= 3'd4);
    assign q_empty    = (q_cnt_q == '0);
    assign cmd_ready  = (q_cnt_q != QCW'(QDEPTH));
    assign q_count    = q_cnt_q;
    assign ch_busy    = busy_q;
    assign s_full     = (s_cnt_q == (SAW + 1)'(SDEPTH));
    assign sts_valid  = (s_cnt_q != '0);
    assign sts_tag    = sts_valid ? s_tag_mem[s_rd_q] : '0;
    assign sts_ch     = sts_valid ? s_ch_mem[s_rd_q]  : '0;
    assign sts_err    = sts_valid ? s_err_mem[s_rd_q] : '0;
    assign sts_illegal = sts_valid ? s_ill_mem[s_rd_q] : 1'b0;

    // Dispatch, completion capture, status arbitration and pointer updates
    always_comb begin
        q_push = cmd_valid && cmd_ready;
        disp   = !q_empty && head_legal && !busy_q[head_ch];
        srv_found = 1'b0;
        srv_ch    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = rr_q + CHW'(i);
            if (!srv_found && pend_q[idx]) begin
                srv_found = 1'b1;
                srv_ch    = idx;
            end
        end
        srv_wr = srv_found && !s_full;
        // An illegal head only gets a status slot when no channel is waiting.
        ill_wr = !srv_found && !s_full && !q_empty && !head_legal;
        s_push = srv_wr || ill_wr;
        s_pop  = sts_valid && sts_ready;
        q_pop  = disp || ill_wr;
        w_tag  = srv_wr ? tag_q[srv_ch] : head_tag;
        w_ch   = srv_wr ? srv_ch : '0;
        w_err  = srv_wr ? err_q[srv_ch] : 3'b000;
        w_ill  = !srv_wr;

        q_wr_d  = q_wr_q + QAW'(q_push);
        q_rd_d  = q_rd_q + QAW'(q_pop);
        q_cnt_d = q_cnt_q + (QAW + 1)'(q_push) - (QAW + 1)'(q_pop);
        s_wr_d  = s_wr_q + SAW'(s_push);
        s_rd_d  = s_rd_q + SAW'(s_pop);
        s_cnt_d = s_cnt_q + (SAW + 1)'(s_push) - (SAW + 1)'(s_pop);

        busy_d = busy_q;
        pend_d = pend_q;
        rr_d   = rr_q;
        for (int c = 0; c < NUM_CH; c++) begin
            err_d[c] = err_q[c];
            cmd_d[c] = cmd_q[c];
            rwa_d[c] = rwa_q[c];
            tag_d[c] = tag_q[c];
            // Completions on idle channels are ignored.
            if (ch_done[c] && busy_q[c] && !pend_q[c]) begin
                pend_d[c] = 1'b1;
                err_d[c]  = {ch_perr[c], ch_eerr[c], ch_rerr[c]};
            end
        end
        if (srv_wr) begin
            pend_d[srv_ch] = 1'b0;
            busy_d[srv_ch] = 1'b0;
            rr_d           = srv_ch + CHW'(1);
        end
        if (disp) begin
            busy_d[head_ch] = 1'b1;
            cmd_d[head_ch]  = head_op;
            rwa_d[head_ch]  = head_row;
            tag_d[head_ch]  = head_tag;
        end
    end

    // Channel outputs: the head is forwarded during the start pulse, then held
    always_comb begin
        ch_strt = '0;
        ch_cmd  = '0;
        ch_rwa  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_strt[c]         = disp && (head_ch == CHW'(c));
            ch_cmd[3*c +: 3]   = (disp && (head_ch == CHW'(c))) ? head_op  : cmd_q[c];
            ch_rwa[RW*c +: RW] = (disp && (head_ch == CHW'(c))) ? head_row : rwa_q[c];
        end
    end

    // Queue and status FIFO payload storage (no reset needed, gated by counts)
    always_ff @(posedge CLK) begin
        if (q_push) begin
            q_op_mem[q_wr_q]  <= cmd_op;
            q_row_mem[q_wr_q] <= cmd_row;
            q_tag_mem[q_wr_q] <= cmd_tag;
        end
        if (s_push) begin
            s_tag_mem[s_wr_q] <= w_tag;
            s_ch_mem[s_wr_q]  <= w_ch;
            s_err_mem[s_wr_q] <= w_err;
            s_ill_mem[s_wr_q] <= w_ill;
        end
    end

    // Control state; asynchronous reset discards all queued and outstanding work
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            q_wr_q  <= '0;
            q_rd_q  <= '0;
            q_cnt_q <= '0;
            s_wr_q  <= '0;
            s_rd_q  <= '0;
            s_cnt_q <= '0;
            busy_q  <= '0;
            pend_q  <= '0;
            rr_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                err_q[c] <= '0;
                cmd_q[c] <= '0;
                rwa_q[c] <= '0;
                tag_q[c] <= '0;
            end
        end else begin
            q_wr_q  <= q_wr_d;
            q_rd_q  <= q_rd_d;
            q_cnt_q <= q_cnt_d;
            s_wr_q  <= s_wr_d;
            s_rd_q  <= s_rd_d;
            s_cnt_q <= s_cnt_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            for (int c = 0; c < NUM_CH; c++) begin
                err_q[c] <= err_d[c];
                cmd_q[c] <= cmd_d[c];
                rwa_q[c] <= rwa_d[c];
                tag_q[c] <= tag_d[c];
            end
        end
    end
endmodule
